// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for a three-register ALU datapath.
// All strobes are Moore decodes of the registered T-step plus the IR fields.
module control_sequencer #(
    parameter int REG_BITS  = 4,
    parameter int CNT_WIDTH = 16,
    localparam int NREG     = 2**REG_BITS
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 run,
    input  logic [31:0]          ir,
    input  logic                 mem_ready,
    output logic                 pco,
    output logic                 pci,
    output logic                 inc_pc,
    output logic                 mari,
    output logic                 read,
    output logic                 mdri,
    output logic                 mdro,
    output logic                 iri,
    output logic                 ryi,
    output logic                 rzi,
    output logic                 rzlo_o,
    output logic [NREG-1:0]      rego,
    output logic [NREG-1:0]      regi,
    output logic [3:0]           alu_op,
    output logic [2:0]           step,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, HALT
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  count_reg;

    logic [4:0]            opcode;
    logic [REG_BITS-1:0]   ra, rb, rc;
    logic [NREG-1:0]       ra_hot, rb_hot, rc_hot;
    logic [3:0]            op_dec;
    logic                  op_legal;
    logic                  unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26 -: REG_BITS];
    assign rb     = ir[26-REG_BITS -: REG_BITS];
    assign rc     = ir[26-2*REG_BITS -: REG_BITS];
    assign unused_ir_bits = ^ir[26-3*REG_BITS:0];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
            assign ra_hot[gi] = (ra == REG_BITS'(gi));
            assign rb_hot[gi] = (rb == REG_BITS'(gi));
            assign rc_hot[gi] = (rc == REG_BITS'(gi));
        end
    endgenerate

    always_comb begin
        op_dec   = 4'b0000;
        op_legal = 1'b1;
        case (opcode)
            5'b00011: op_dec = 4'b0001;
            5'b00100: op_dec = 4'b0010;
            5'b00101: op_dec = 4'b0011;
            5'b00110: op_dec = 4'b0100;
            5'b00111: op_dec = 4'b0101;
            5'b01000: op_dec = 4'b0110;
            5'b01001: op_dec = 4'b0111;
            5'b01010: op_dec = 4'b1000;
            default:  op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == T5)
                count_reg <= count_reg + 1'b1;
        end
    end

    assign instr_count = count_reg;

    always_comb begin
        state_next = state_reg;
        pco    = 1'b0;
        pci    = 1'b0;
        inc_pc = 1'b0;
        mari   = 1'b0;
        read   = 1'b0;
        mdri   = 1'b0;
        mdro   = 1'b0;
        iri    = 1'b0;
        ryi    = 1'b0;
        rzi    = 1'b0;
        rzlo_o = 1'b0;
        rego   = '0;
        regi   = '0;
        alu_op = 4'b0000;
        step   = 3'd7;
        halted = 1'b0;
        case (state_reg)
            IDLE: if (run) state_next = T0;
            T0: begin
                step   = 3'd0;
                pco    = 1'b1;
                mari   = 1'b1;
                inc_pc = 1'b1;
                rzi    = 1'b1;
                alu_op = 4'b1001;
                state_next = T1;
            end
            T1: begin
                // Held through the stall; reloading PC from Z is idempotent.
                step   = 3'd1;
                rzlo_o = 1'b1;
                pci    = 1'b1;
                read   = 1'b1;
                mdri   = 1'b1;
                if (mem_ready) state_next = T2;
            end
            T2: begin
                step = 3'd2;
                mdro = 1'b1;
                iri  = 1'b1;
                state_next = T3;
            end
            T3: begin
                step = 3'd3;
                if (op_legal) begin
                    rego = rb_hot;
                    ryi  = 1'b1;
                    state_next = T4;
                end else begin
                    state_next = HALT;
                end
            end
            T4: begin
                step   = 3'd4;
                rego   = rc_hot;
                alu_op = op_dec;
                rzi    = 1'b1;
                state_next = T5;
            end
            T5: begin
                step   = 3'd5;
                rzlo_o = 1'b1;
                regi   = ra_hot;
                state_next = run ? T0 : IDLE;
            end
            HALT: halted = 1'b1;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand-written corner sequences.
module tb_control_sequencer;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic        pco, pci, inc_pc, mari, read, mdri, mdro, iri, ryi, rzi, rzlo_o;
    logic [15:0] rego, regi;
    logic [3:0]  alu_op;
    logic [2:0]  step;
    logic        halted;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    control_sequencer #(.REG_BITS(4), .CNT_WIDTH(16)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .pco(pco), .pci(pci), .inc_pc(inc_pc), .mari(mari), .read(read), .mdri(mdri),
        .mdro(mdro), .iri(iri), .ryi(ryi), .rzi(rzi), .rzlo_o(rzlo_o),
        .rego(rego), .regi(regi), .alu_op(alu_op), .step(step), .halted(halted),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe vector order: {pco,pci,inc_pc,mari,read,mdri,mdro,iri,ryi,rzi,rzlo_o}
    localparam logic [10:0] P0 = 11'b101_1000_0010;
    localparam logic [10:0] P1 = 11'b010_0110_0001;
    localparam logic [10:0] P2 = 11'b000_0001_1000;
    localparam logic [10:0] P3 = 11'b000_0000_0100;
    localparam logic [10:0] P4 = 11'b000_0000_0010;
    localparam logic [10:0] P5 = 11'b000_0000_0001;
    localparam logic [10:0] PZ = 11'b000_0000_0000;

    localparam logic [31:0] I_AND  = 32'h28918000;
    localparam logic [31:0] I_ROL  = 32'h48080000;
    localparam logic [31:0] I_H1B  = 32'hD8000000;
    localparam logic [31:0] I_H1F  = 32'hF8000000;

    typedef struct {
        logic        clr;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [2:0]  step;
        logic [10:0] strb;
        logic [15:0] rego;
        logic [15:0] regi;
        logic [3:0]  alu;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic add(logic clr, logic r, logic mr, logic [31:0] i, logic [2:0] s, logic [10:0] st,
                       logic [15:0] ro, logic [15:0] ri, logic [3:0] al, logic h, logic [15:0] c);
        vec_t v;
        v.clr = clr; v.run = r; v.mr = mr; v.ir = i; v.step = s; v.strb = st;
        v.rego = ro; v.regi = ri; v.alu = al; v.halted = h; v.cnt = c;
        vecs.push_back(v);
    endtask

    function automatic logic [79:0] observed();
        return {13'd0, step, pco, pci, inc_pc, mari, read, mdri, mdro, iri, ryi, rzi, rzlo_o,
                rego, regi, alu_op, halted, instr_count};
    endfunction

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] i_ror;
    int          drivers;
    bit          done6;

    initial begin
        i_ror = mk_ir(5'b01010, 4'd15, 4'd14, 4'd13);
        // clr run mr ir        step strobes rego      regi      alu  h cnt
        add(0,1,1,I_AND, 3'd0,P0,16'h0000,16'h0000,4'h9,0,16'd0);
        add(0,1,1,I_AND, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_AND, 3'd2,P2,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_AND, 3'd3,P3,16'h0004,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_AND, 3'd4,P4,16'h0008,16'h0000,4'h3,0,16'd0);
        add(0,1,1,I_AND, 3'd5,P5,16'h0000,16'h0002,4'h0,0,16'd0);
        add(0,1,1,I_ROL, 3'd0,P0,16'h0000,16'h0000,4'h9,0,16'd1);
        add(0,1,1,I_ROL, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd1);
        add(0,1,1,I_ROL, 3'd2,P2,16'h0000,16'h0000,4'h0,0,16'd1);
        add(0,1,1,I_ROL, 3'd3,P3,16'h0002,16'h0000,4'h0,0,16'd1);
        add(0,1,1,I_ROL, 3'd4,P4,16'h0001,16'h0000,4'h7,0,16'd1);
        add(0,1,1,I_ROL, 3'd5,P5,16'h0000,16'h0001,4'h0,0,16'd1);
        add(0,0,1,I_ROL, 3'd7,PZ,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,0,1,I_ROL, 3'd7,PZ,16'h0000,16'h0000,4'h0,0,16'd2);
        // memory stall: three mem_ready-low edges in T1
        add(0,1,0,I_ROL, 3'd0,P0,16'h0000,16'h0000,4'h9,0,16'd2);
        add(0,1,0,I_ROL, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,0,I_ROL, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,0,I_ROL, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,0,I_ROL, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,1,I_H1B, 3'd2,P2,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,1,I_H1B, 3'd3,PZ,16'h0000,16'h0000,4'h0,0,16'd2);
        add(0,1,1,I_H1B, 3'd7,PZ,16'h0000,16'h0000,4'h0,1,16'd2);
        add(0,1,1,I_H1B, 3'd7,PZ,16'h0000,16'h0000,4'h0,1,16'd2);
        add(1,1,1,I_H1F, 3'd7,PZ,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_H1F, 3'd0,P0,16'h0000,16'h0000,4'h9,0,16'd0);
        add(0,1,1,I_H1F, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_H1F, 3'd2,P2,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_H1F, 3'd3,PZ,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,I_H1F, 3'd7,PZ,16'h0000,16'h0000,4'h0,1,16'd0);
        add(1,0,1,i_ror, 3'd7,PZ,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,i_ror, 3'd0,P0,16'h0000,16'h0000,4'h9,0,16'd0);
        add(0,1,1,i_ror, 3'd1,P1,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,i_ror, 3'd2,P2,16'h0000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,i_ror, 3'd3,P3,16'h4000,16'h0000,4'h0,0,16'd0);
        add(0,1,1,i_ror, 3'd4,P4,16'h2000,16'h0000,4'h8,0,16'd0);
        add(0,0,1,i_ror, 3'd5,P5,16'h0000,16'h8000,4'h0,0,16'd0);
        add(0,0,1,i_ror, 3'd7,PZ,16'h0000,16'h0000,4'h0,0,16'd1);

        // reset state
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        tick(); tick();
        check("reset", observed(), {13'd0, 3'd7, PZ, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0});

        foreach (vecs[k]) begin
            @(negedge clock);
            clear = vecs[k].clr; run = vecs[k].run; mem_ready = vecs[k].mr; ir = vecs[k].ir;
            tick();
            check($sformatf("vec%0d", k), observed(),
                  {13'd0, vecs[k].step, vecs[k].strb, vecs[k].rego, vecs[k].regi,
                   vecs[k].alu, vecs[k].halted, vecs[k].cnt});
            $display("vec%0d step=%0d strb=%b rego=%h regi=%h alu=%h halted=%b cnt=%0d",
                     k, step, {pco,pci,inc_pc,mari,read,mdri,mdro,iri,ryi,rzi,rzlo_o},
                     rego, regi, alu_op, halted, instr_count);
        end

        // clear pulse in the middle of T4, after one retired instruction
        @(negedge clock);
        clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = I_AND;
        repeat (6) tick();
        repeat (5) tick();
        check("mid_t4_reached", {77'd0, step}, {77'd0, 3'd4});
        #2 clear = 1'b1;
        #1 check("async_clear", observed(), {13'd0, 3'd7, PZ, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0});
        tick();
        check("clear_held", observed(), {13'd0, 3'd7, PZ, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0});
        @(negedge clock);
        clear = 1'b0;
        tick();
        check("restart_t0", observed(), {13'd0, 3'd0, P0, 16'h0, 16'h0, 4'h9, 1'b0, 16'd0});
        $display("clear test step=%0d cnt=%0d", step, instr_count);

        // back-to-back run, dropped during the second T2; single bus driver each cycle
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0; run = 1'b1; ir = I_AND;
        done6 = 1'b0;
        for (int c = 0; c < 40 && !done6; c++) begin
            tick();
            drivers = int'(pco) + int'(rzlo_o) + int'(mdro) + ((rego != 16'h0) ? 1 : 0);
            check($sformatf("bus_c%0d", c), {78'd0, (drivers <= 1), ($countones(rego) <= 1)},
                  {78'd0, 2'b11});
            if (step == 3'd2 && instr_count == 16'd1) begin
                @(negedge clock);
                run = 1'b0;
            end
            if (step == 3'd7) done6 = 1'b1;
        end
        check("run_drop_idle", {79'd0, done6}, {79'd0, 1'b1});
        check("run_drop_count", {64'd0, instr_count}, {64'd0, 16'd2});
        $display("run drop test step=%0d cnt=%0d", step, instr_count);
        tick();
        check("idle_stays", {61'd0, step, instr_count}, {61'd0, 3'd7, 16'd2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
